// File: rtl/kv_pkg.sv
// Shared encodings for the key-value store Wishbone initiator: host ops, sel-bit key
// encodings, and FSM states.
package kv_pkg;

    typedef enum logic [1:0] {
        OP_PUT  = 2'b00,
        OP_GET  = 2'b01,
        OP_RGET = 2'b10,
        OP_ILL  = 2'b11
    } op_e;

    localparam logic [3:0] SEL_ADR_IS_KEY = 4'b0001;
    localparam logic [3:0] SEL_DAT_IS_KEY = 4'b0010;

    localparam int unsigned DUP_BIT = 16;

    typedef enum logic [1:0] {
        IDLE,
        BUS,
        RESP
    } state_e;

    // Reverse lookup tells the store that the data word carries the key.
    function automatic logic [3:0] op_to_sel(input op_e op);
        return (op == OP_RGET) ? SEL_DAT_IS_KEY : SEL_ADR_IS_KEY;
    endfunction

endpackage

// File: rtl/kv_wb_timer.sv
// Saturating 16-bit bus-cycle timer. The expired_o output flags the last allowed
// cycle, so the FSM leaves BUS after exactly TIMEOUT_CYCLES cycles.
module kv_wb_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam logic [15:0] LastCnt = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = 16'd0;
        end else if (en_i && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= 16'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q >= LastCnt);

endmodule

// File: rtl/kv_wb_initiator.sv
// Wishbone classic-cycle initiator for the key-value store: one command in flight,
// single-beat bus cycle, registered response with error and duplicate flags.
module kv_wb_initiator
    import kv_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] BASE_ADDR      = 32'h3000_0000
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic [1:0]  cmd_op_i,
    input  logic [15:0] cmd_key_i,
    input  logic [15:0] cmd_val_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [15:0] rsp_data_o,
    output logic        rsp_dup_o,
    output logic        rsp_err_o,
    output logic        busy_o,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic        wbm_ack_i,
    input  logic [31:0] wbm_dat_i
);

    state_e      state_q, state_d;
    logic        cyc_q, cyc_d;
    logic        we_q, we_d;
    logic [3:0]  sel_q, sel_d;
    logic [31:0] adr_q, adr_d;
    logic [31:0] dat_q, dat_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [15:0] rsp_data_q, rsp_data_d;
    logic        rsp_dup_q, rsp_dup_d;
    logic        rsp_err_q, rsp_err_d;
    logic        cmd_ready_q, cmd_ready_d;

    logic        accept;
    logic        expired;
    op_e         op;
    logic        unused_dat;

    assign op         = op_e'(cmd_op_i);
    assign accept     = cmd_ready_q && cmd_valid_i;
    assign unused_dat = ^wbm_dat_i[31:17];

    kv_wb_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk_i    (wb_clk_i),
        .rst_i    (wb_rst_i),
        .clr_i    (accept),
        .en_i     (state_q == BUS),
        .expired_o(expired)
    );

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q     <= IDLE;
            cyc_q       <= 1'b0;
            we_q        <= 1'b0;
            sel_q       <= 4'd0;
            adr_q       <= 32'd0;
            dat_q       <= 32'd0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 16'd0;
            rsp_dup_q   <= 1'b0;
            rsp_err_q   <= 1'b0;
            cmd_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cyc_q       <= cyc_d;
            we_q        <= we_d;
            sel_q       <= sel_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_dup_q   <= rsp_dup_d;
            rsp_err_q   <= rsp_err_d;
            cmd_ready_q <= cmd_ready_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = (op == OP_ILL) ? RESP : BUS;
            BUS:  if (wbm_ack_i || expired) state_d = RESP;
            RESP: if (rsp_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cyc_d       = cyc_q;
        we_d        = we_q;
        sel_d       = sel_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_dup_d   = rsp_dup_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (accept && (op == OP_ILL)) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_data_d  = 16'd0;
                    rsp_dup_d   = 1'b0;
                end else if (accept) begin
                    cyc_d = 1'b1;
                    we_d  = (op == OP_PUT);
                    sel_d = op_to_sel(op);
                    adr_d = {BASE_ADDR[31:16], cmd_key_i};
                    dat_d = {16'h0000, cmd_val_i};
                end
            end
            BUS: begin
                // Ack has priority over a timeout landing on the same cycle.
                if (wbm_ack_i) begin
                    cyc_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = wbm_dat_i[15:0];
                    rsp_dup_d   = wbm_dat_i[DUP_BIT];
                    rsp_err_d   = 1'b0;
                end else if (expired) begin
                    cyc_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = 16'd0;
                    rsp_dup_d   = 1'b0;
                    rsp_err_d   = 1'b1;
                end
            end
            RESP: if (rsp_ready_i) rsp_valid_d = 1'b0;
            default: begin
                cyc_d       = 1'b0;
                rsp_valid_d = 1'b0;
            end
        endcase
        cmd_ready_d = (state_d == IDLE);
    end

    assign cmd_ready_o = cmd_ready_q;
    assign busy_o      = (state_q != IDLE);
    assign wbm_cyc_o   = cyc_q;
    assign wbm_stb_o   = cyc_q;
    assign wbm_we_o    = we_q;
    assign wbm_sel_o   = sel_q;
    assign wbm_adr_o   = adr_q;
    assign wbm_dat_o   = dat_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_data_o  = rsp_data_q;
    assign rsp_dup_o   = rsp_dup_q;
    assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_kv_wb_initiator.sv
// Scoreboard bench for kv_wb_initiator: a negedge slave model acks on a planned
// bus cycle, and a monitor checks every response handshake against a queue.
module tb_kv_wb_initiator;

    typedef struct packed {
        logic [15:0] data;
        logic        dup;
        logic        err;
    } rsp_t;

    logic        clk = 1'b0;
    logic        wb_rst_i;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic [1:0]  cmd_op_i;
    logic [15:0] cmd_key_i;
    logic [15:0] cmd_val_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [15:0] rsp_data_o;
    logic        rsp_dup_o;
    logic        rsp_err_o;
    logic        busy_o;
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic        wbm_ack_i;
    logic [31:0] wbm_dat_i;

    rsp_t        exp_q[$];
    int          n_vec = 0;
    int          n_fail = 0;
    int          ack_cycle = 0;
    logic [31:0] rdata = 32'd0;
    logic        stray_ack = 1'b0;
    int          bus_cyc = 0;
    int          last_len = 0;

    always #5 clk = ~clk;

    kv_wb_initiator #(
        .TIMEOUT_CYCLES(8),
        .BASE_ADDR     (32'h3000_0000)
    ) dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (wb_rst_i),
        .cmd_valid_i(cmd_valid_i),
        .cmd_ready_o(cmd_ready_o),
        .cmd_op_i   (cmd_op_i),
        .cmd_key_i  (cmd_key_i),
        .cmd_val_i  (cmd_val_i),
        .rsp_valid_o(rsp_valid_o),
        .rsp_ready_i(rsp_ready_i),
        .rsp_data_o (rsp_data_o),
        .rsp_dup_o  (rsp_dup_o),
        .rsp_err_o  (rsp_err_o),
        .busy_o     (busy_o),
        .wbm_cyc_o  (wbm_cyc_o),
        .wbm_stb_o  (wbm_stb_o),
        .wbm_we_o   (wbm_we_o),
        .wbm_sel_o  (wbm_sel_o),
        .wbm_adr_o  (wbm_adr_o),
        .wbm_dat_o  (wbm_dat_o),
        .wbm_ack_i  (wbm_ack_i),
        .wbm_dat_i  (wbm_dat_i)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Slave: counts stb cycles mid-cycle, acks on the planned one, garbage data otherwise.
    initial begin
        wbm_ack_i = 1'b0;
        wbm_dat_i = 32'd0;
        forever begin
            @(negedge clk);
            if (wbm_cyc_o && wbm_stb_o) begin
                bus_cyc++;
                wbm_ack_i = (bus_cyc == ack_cycle);
            end else begin
                if (bus_cyc != 0) last_len = bus_cyc;
                bus_cyc   = 0;
                wbm_ack_i = stray_ack;
            end
            wbm_dat_i = wbm_ack_i ? rdata : 32'hFFFF_FFFF;
        end
    end

    initial begin
        rsp_t got;
        rsp_t exp_r;
        forever begin
            @(negedge clk);
            if (rsp_valid_o && rsp_ready_i) begin
                got = {rsp_data_o, rsp_dup_o, rsp_err_o};
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_fail++;
                    $display("FAIL rsp_unexpected: got %h expected none", got);
                end else begin
                    exp_r = exp_q.pop_front();
                    chk("rsp", 64'(got), 64'(exp_r));
                end
            end
        end
    end

    task automatic do_cmd(input string name, input logic [1:0] op, input logic [15:0] key,
                          input logic [15:0] val, input int ack_c, input logic [31:0] rd,
                          input logic e_we, input logic [3:0] e_sel, input logic [15:0] e_data,
                          input logic e_dup, input logic e_err, input int e_lat,
                          input int e_len, input int bp);
        int   w;
        int   lat;
        rsp_t dropped;
        w = 0;
        while (!cmd_ready_o && w < 20) begin
            @(posedge clk); #1;
            w++;
        end
        chk({name, "_cmd_ready"}, 64'(cmd_ready_o), 64'd1);
        if (!cmd_ready_o) return;
        ack_cycle = ack_c;
        rdata     = rd;
        exp_q.push_back({e_data, e_dup, e_err});
        cmd_valid_i = 1'b1;
        cmd_op_i    = op;
        cmd_key_i   = key;
        cmd_val_i   = val;
        @(posedge clk); #1;
        cmd_valid_i = 1'b0;
        chk({name, "_busy"}, 64'(busy_o), 64'd1);
        if (op != 2'b11) begin
            chk({name, "_ctl"}, 64'({wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o}),
                64'({2'b11, e_we, e_sel}));
            chk({name, "_adr"}, 64'(wbm_adr_o), 64'({16'h3000, key}));
            chk({name, "_dat"}, 64'(wbm_dat_o), 64'({16'h0000, val}));
        end else begin
            chk({name, "_nocyc"}, 64'({wbm_cyc_o, wbm_stb_o}), 64'd0);
        end
        lat = 1;
        while (!rsp_valid_o && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({name, "_latency"}, 64'(lat), 64'(e_lat));
        if (!rsp_valid_o) begin
            dropped = exp_q.pop_back();
            return;
        end
        chk({name, "_cyc_low"}, 64'({wbm_cyc_o, wbm_stb_o}), 64'd0);
        for (int i = 0; i < bp; i++) begin
            chk({name, "_hold"}, 64'({cmd_ready_o, rsp_valid_o, rsp_data_o, rsp_dup_o, rsp_err_o}),
                64'({1'b0, 1'b1, e_data, e_dup, e_err}));
            @(posedge clk); #1;
        end
        rsp_ready_i = 1'b1;
        @(posedge clk); #1;
        rsp_ready_i = 1'b0;
        chk({name, "_done"}, 64'({rsp_valid_o, cmd_ready_o, busy_o}), 64'({1'b0, 1'b1, 1'b0}));
        if (e_len > 0) chk({name, "_bus_len"}, 64'(last_len), 64'(e_len));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        wb_rst_i    = 1'b1;
        cmd_valid_i = 1'b0;
        cmd_op_i    = 2'b00;
        cmd_key_i   = 16'd0;
        cmd_val_i   = 16'd0;
        rsp_ready_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ctl", 64'({cmd_ready_o, rsp_valid_o, rsp_data_o, rsp_dup_o, rsp_err_o, busy_o,
                              wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o}), 64'd0);
        chk("reset_bus", 64'({wbm_adr_o, wbm_dat_o}), 64'd0);
        wb_rst_i = 1'b0;

        // name, op, key, val, ack_cycle, rdata, we, sel, data, dup, err, latency, bus_len, bp
        do_cmd("put", 2'b00, 16'h0042, 16'h1234, 3, 32'h0000_0000,
               1'b1, 4'b0001, 16'h0000, 1'b0, 1'b0, 4, 3, 0);
        do_cmd("put_dup", 2'b00, 16'h0042, 16'h5555, 1, 32'h0001_0000,
               1'b1, 4'b0001, 16'h0000, 1'b1, 1'b0, 2, 1, 0);
        do_cmd("get_hit", 2'b01, 16'h0042, 16'h0000, 1, 32'h0001_1234,
               1'b0, 4'b0001, 16'h1234, 1'b1, 1'b0, 2, 1, 0);
        do_cmd("rget", 2'b10, 16'h0000, 16'h1234, 2, 32'h0000_0042,
               1'b0, 4'b0010, 16'h0042, 1'b0, 1'b0, 3, 2, 0);
        do_cmd("timeout", 2'b01, 16'h0007, 16'h0000, 0, 32'h0000_0000,
               1'b0, 4'b0001, 16'h0000, 1'b0, 1'b1, 9, 8, 0);
        do_cmd("collide", 2'b01, 16'h0008, 16'h0000, 8, 32'h0000_BEEF,
               1'b0, 4'b0001, 16'hBEEF, 1'b0, 1'b0, 9, 8, 0);

        stray_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("stray_ack", 64'({rsp_valid_o, busy_o, wbm_cyc_o}), 64'd0);
        end
        stray_ack = 1'b0;
        @(posedge clk); #1;

        do_cmd("illegal", 2'b11, 16'h0055, 16'h0066, 0, 32'h0000_0000,
               1'b0, 4'b0000, 16'h0000, 1'b0, 1'b1, 1, 0, 0);

        // Reset in the middle of a bus cycle: no response may surface.
        ack_cycle   = 0;
        cmd_valid_i = 1'b1;
        cmd_op_i    = 2'b01;
        cmd_key_i   = 16'h0009;
        @(posedge clk); #1;
        cmd_valid_i = 1'b0;
        chk("rst_mid_cyc", 64'(wbm_cyc_o), 64'd1);
        repeat (2) @(posedge clk);
        #1;
        wb_rst_i = 1'b1;
        @(posedge clk); #1;
        chk("rst_mid_drop", 64'({wbm_cyc_o, wbm_stb_o, rsp_valid_o, busy_o, cmd_ready_o}), 64'd0);
        wb_rst_i = 1'b0;

        do_cmd("after_rst", 2'b01, 16'h0042, 16'h0000, 1, 32'h0000_5678,
               1'b0, 4'b0001, 16'h5678, 1'b0, 1'b0, 2, 1, 0);
        do_cmd("backpress", 2'b01, 16'h00A5, 16'h0000, 2, 32'h0001_C0DE,
               1'b0, 4'b0001, 16'hC0DE, 1'b1, 1'b0, 3, 2, 5);

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drain", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
